// File: rtl/wptr_handler.sv
// Write-domain pointer and flag generator for an asynchronous FIFO.
// Produces binary/Gray write pointers, registered full/half-full/level, and overflow reporting.
module wptr_handler #(
    parameter int PTR_WIDTH   = 8,
    parameter int HALF_THRESH = 2 ** (PTR_WIDTH - 1),
    parameter int DROP_CNT_W  = 8
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  w_en,
    input  logic [PTR_WIDTH:0]    g_rptr_sync,
    input  logic                  ovf_clr,
    output logic [PTR_WIDTH:0]    b_wptr,
    output logic [PTR_WIDTH:0]    g_wptr,
    output logic                  full,
    output logic                  halffull,
    output logic [PTR_WIDTH:0]    wr_level,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [PTR_WIDTH:0] HALF_THRESH_W = (PTR_WIDTH + 1)'(HALF_THRESH);

    function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
        logic [PTR_WIDTH:0] b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = g[i] ^ b[i + 1];
        end
        return b;
    endfunction

    logic [PTR_WIDTH:0]    b_wptr_q, b_wptr_d;
    logic [PTR_WIDTH:0]    g_wptr_q, g_wptr_d;
    logic [PTR_WIDTH:0]    level_q, level_d;
    logic                  full_q, full_d;
    logic                  halffull_q, halffull_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic                  accept;
    logic                  reject;
    logic [PTR_WIDTH:0]    b_rptr_sync;
    logic [PTR_WIDTH:0]    full_pattern;

    // Full when the write pointer is one lap ahead: the two MSBs of the Gray read
    // pointer are inverted, the remaining bits equal.
    assign full_pattern = {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]};
    assign b_rptr_sync  = gray2bin(g_rptr_sync);

    assign accept = w_en & ~full_q;
    assign reject = w_en & full_q;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        b_wptr_d   = b_wptr_q + (PTR_WIDTH + 1)'(accept);
        g_wptr_d   = (b_wptr_d >> 1) ^ b_wptr_d;
        full_d     = (g_wptr_d == full_pattern);
        level_d    = b_wptr_d - b_rptr_sync;
        halffull_d = (level_d >= HALF_THRESH_W);

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (reject) begin
            // A rejected write outranks a simultaneous clear: the count restarts at one.
            overflow_d = 1'b1;
            if (ovf_clr) begin
                drop_cnt_d = DROP_CNT_W'(1);
            end else if (~&drop_cnt_q) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            end
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            b_wptr_q   <= '0;
            g_wptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            halffull_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            b_wptr_q   <= b_wptr_d;
            g_wptr_q   <= g_wptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            halffull_q <= halffull_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign b_wptr   = b_wptr_q;
    assign g_wptr   = g_wptr_q;
    assign wr_level = level_q;
    assign full     = full_q;
    assign halffull = halffull_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_wptr_handler.sv
// Directed bench for wptr_handler: vector table plus hand-written fill, wrap and overflow sequences.
module tb_wptr_handler;

    localparam int PW = 8;
    localparam int DW = 8;

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic          w_en;
    logic [PW:0]   g_rptr_sync;
    logic          ovf_clr;
    logic [PW:0]   b_wptr;
    logic [PW:0]   g_wptr;
    logic          full;
    logic          halffull;
    logic [PW:0]   wr_level;
    logic          overflow;
    logic [DW-1:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    wptr_handler #(
        .PTR_WIDTH  (PW),
        .HALF_THRESH(128),
        .DROP_CNT_W (DW)
    ) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .w_en       (w_en),
        .g_rptr_sync(g_rptr_sync),
        .ovf_clr    (ovf_clr),
        .b_wptr     (b_wptr),
        .g_wptr     (g_wptr),
        .full       (full),
        .halffull   (halffull),
        .wr_level   (wr_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic          w_en;
        logic [PW:0]   g_rptr;
        logic          clr;
        logic [PW:0]   b;
        logic [PW:0]   g;
        logic          full;
        logic [PW:0]   lvl;
        logic          hf;
        logic          ovf;
        logic [DW-1:0] drop;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [PW:0] b, input logic [PW:0] g,
                             input logic f, input logic [PW:0] lvl, input logic hf,
                             input logic ovf, input logic [DW-1:0] drop);
        check($sformatf("%s.b_wptr", tag),   32'(b_wptr),   32'(b));
        check($sformatf("%s.g_wptr", tag),   32'(g_wptr),   32'(g));
        check($sformatf("%s.full", tag),     32'(full),     32'(f));
        check($sformatf("%s.wr_level", tag), 32'(wr_level), 32'(lvl));
        check($sformatf("%s.halffull", tag), 32'(halffull), 32'(hf));
        check($sformatf("%s.overflow", tag), 32'(overflow), 32'(ovf));
        check($sformatf("%s.drop_cnt", tag), 32'(drop_cnt), 32'(drop));
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        step();
        step();
        wrst_n = 1'b1;
    endtask

    function automatic logic [PW:0] bin2gray(input logic [PW:0] b);
        return (b >> 1) ^ b;
    endfunction

    initial begin
        logic [PW:0] prev_g;
        logic [PW:0] model_b;

        // w_en, g_rptr, clr | b, g, full, lvl, hf, ovf, drop
        vecs[0] = '{1'b1, 9'h000, 1'b0, 9'h001, 9'h001, 1'b0, 9'd1, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{1'b1, 9'h000, 1'b0, 9'h002, 9'h003, 1'b0, 9'd2, 1'b0, 1'b0, 8'd0};
        vecs[2] = '{1'b0, 9'h001, 1'b0, 9'h002, 9'h003, 1'b0, 9'd1, 1'b0, 1'b0, 8'd0};
        vecs[3] = '{1'b1, 9'h003, 1'b0, 9'h003, 9'h002, 1'b0, 9'd1, 1'b0, 1'b0, 8'd0};
        vecs[4] = '{1'b0, 9'h003, 1'b0, 9'h003, 9'h002, 1'b0, 9'd1, 1'b0, 1'b0, 8'd0};
        vecs[5] = '{1'b1, 9'h002, 1'b0, 9'h004, 9'h006, 1'b0, 9'd1, 1'b0, 1'b0, 8'd0};
        vecs[6] = '{1'b0, 9'h006, 1'b0, 9'h004, 9'h006, 1'b0, 9'd0, 1'b0, 1'b0, 8'd0};
        vecs[7] = '{1'b0, 9'h006, 1'b1, 9'h004, 9'h006, 1'b0, 9'd0, 1'b0, 1'b0, 8'd0};

        w_en        = 1'b0;
        g_rptr_sync = '0;
        ovf_clr     = 1'b0;
        wrst_n      = 1'b1;
        #2;
        do_reset();
        check_all("reset", 9'h000, 9'h000, 1'b0, 9'd0, 1'b0, 1'b0, 8'd0);

        for (int i = 0; i < 8; i++) begin
            w_en        = vecs[i].w_en;
            g_rptr_sync = vecs[i].g_rptr;
            ovf_clr     = vecs[i].clr;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].b, vecs[i].g, vecs[i].full,
                      vecs[i].lvl, vecs[i].hf, vecs[i].ovf, vecs[i].drop);
        end

        // Asynchronous reset mid-run, sampled before any clock edge.
        w_en    = 1'b0;
        ovf_clr = 1'b0;
        wrst_n  = 1'b0;
        #2;
        check_all("async_rst", 9'h000, 9'h000, 1'b0, 9'd0, 1'b0, 1'b0, 8'd0);
        step();
        g_rptr_sync = '0;
        wrst_n      = 1'b1;
        step();
        step();
        check_all("post_rst", 9'h000, 9'h000, 1'b0, 9'd0, 1'b0, 1'b0, 8'd0);

        // Fill from empty with the reader parked at zero.
        w_en = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step();
            if (i == 127) begin
                check("fill127.halffull", 32'(halffull), 32'd0);
                check("fill127.wr_level", 32'(wr_level), 32'd127);
            end
            if (i == 128) begin
                check("fill128.halffull", 32'(halffull), 32'd1);
                check("fill128.wr_level", 32'(wr_level), 32'd128);
            end
            if (i == 255) check("fill255.full", 32'(full), 32'd0);
        end
        check_all("fill256", 9'h100, 9'h180, 1'b1, 9'd256, 1'b1, 1'b0, 8'd0);
        step();
        check_all("write257", 9'h100, 9'h180, 1'b1, 9'd256, 1'b1, 1'b1, 8'd1);

        // One read becomes visible: one slot frees, then one write refills it.
        w_en        = 1'b0;
        g_rptr_sync = 9'h001;
        step();
        check_all("release", 9'h100, 9'h180, 1'b0, 9'd255, 1'b1, 1'b1, 8'd1);
        w_en = 1'b1;
        step();
        check_all("refill", 9'h101, 9'h181, 1'b1, 9'd256, 1'b1, 1'b1, 8'd1);

        // Build drop_cnt up to 5, then race a clear against a rejected write.
        for (int i = 0; i < 4; i++) step();
        check("drop5.drop_cnt", 32'(drop_cnt), 32'd5);
        ovf_clr = 1'b1;
        step();
        check("race.overflow", 32'(overflow), 32'd1);
        check("race.drop_cnt", 32'(drop_cnt), 32'd1);
        w_en = 1'b0;
        step();
        check("clear.overflow", 32'(overflow), 32'd0);
        check("clear.drop_cnt", 32'(drop_cnt), 32'd0);
        ovf_clr = 1'b0;
        w_en    = 1'b1;
        for (int i = 0; i < 300; i++) step();
        check("sat.drop_cnt", 32'(drop_cnt), 32'd255);
        check("sat.overflow", 32'(overflow), 32'd1);
        check("sat.b_wptr_held", 32'(b_wptr), 32'h101);

        // Wrap with the reader trailing one entry behind.
        w_en = 1'b0;
        do_reset();
        model_b = '0;
        prev_g  = g_wptr;
        w_en    = 1'b1;
        for (int i = 0; i < 600; i++) begin
            g_rptr_sync = bin2gray(model_b);
            model_b     = model_b + 9'd1;
            step();
            check("wrap.b_wptr", 32'(b_wptr), 32'(model_b));
            check("wrap.gray_step", 32'($countones(g_wptr ^ prev_g) <= 1), 32'd1);
            check("wrap.full", 32'(full), 32'd0);
            if (i == 511) begin
                check("wrap0.b_wptr", 32'(b_wptr), 32'h000);
                check("wrap0.g_wptr", 32'(g_wptr), 32'h000);
            end
            prev_g = g_wptr;
        end
        check("wrap.wr_level", 32'(wr_level), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
